// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the hazard/control unit.
//   - state_t   : control FSM state (RUN, FLUSH)
//   - ADDR_*    : addrSel encodings driven to the IF/PC next-address mux
//   - flush_cnt_t / flush_init(): flush countdown width and its start value
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Next-PC source select
   localparam logic [1:0] ADDR_SEQ     = 2'b00;  // PC+4
   localparam logic [1:0] ADDR_JUMP    = 2'b01;  // jump target
   localparam logic [1:0] ADDR_BR_TGT  = 2'b10;  // branch target
   localparam logic [1:0] ADDR_BR_FALL = 2'b11;  // branch fall-through (recovery)

   // Flush length is 1..3 bubbles, so the countdown fits in two bits.
   localparam int FLUSH_CNT_W = 2;
   typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

   // Countdown start value for a given flush length. Out-of-range lengths
   // are clamped into 1..3 so the counter can never wrap.
   function automatic flush_cnt_t flush_init(input int flush_cycles);
      int n;
      n = flush_cycles;
      if (n < 1) n = 1;
      if (n > 3) n = 3;
      return flush_cnt_t'(n - 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_bp_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating event counter. Increments by one on every clock where inc is
//   high and holds at all-ones instead of wrapping.
//   Ports:
//     Clk   in  : rising-edge clock
//     Rst   in  : asynchronous active-high reset, clears count
//     inc   in  : count this cycle
//     count out : current value (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl_bp.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_bp
//   Hazard/control unit for a 5-stage MIPS pipeline that resolves branches in
//   ID. Stalls on load-use and jr-operand hazards, redirects fetch on branch
//   mispredictions and jumps, inserts FLUSH_CYCLES bubbles after a redirect,
//   trains the branch predictor and keeps saturating stall/flush counters.
//
//   Parameters:
//     REG_W        register-specifier width
//     FLUSH_CYCLES bubble cycles after a redirect (1..3)
//     PRED_EXT     0: static not-taken, 1: use PredTaken
//     CNT_W        performance-counter width
//
//   Ports:
//     Clk, Rst                      clock, async active-high reset
//     Jump, Jr, Branch              ID instruction class
//     ALUZero                       ID branch outcome (1 = taken)
//     PredTaken                     fetch followed the taken path
//     memReadEX                     EX holds a load
//     UseShamt, UseImmed            ID instruction does not read currRt
//     currRs, currRt, prevRt        ID sources / EX load destination
//     EX_Rw, MEM_Rw, *_RegWrite     in-flight register writers
//     IF_write, PC_write, bubble    IF/ID enable, PC enable, ID/EX bubble
//     addrSel                       next-PC select (see hazard_pkg ADDR_*)
//     Mispredict                    wrong-prediction pulse
//     UpdValid, UpdTaken            predictor training strobe / outcome
//     StallCount, FlushCount        saturating performance counters
//
//   All outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl_bp
   import hazard_pkg::*;
#(
   parameter int REG_W        = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int PRED_EXT     = 0,
   parameter int CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Jump,
   input  logic             Jr,
   input  logic             Branch,
   input  logic             ALUZero,
   input  logic             PredTaken,
   input  logic             memReadEX,
   input  logic             UseShamt,
   input  logic             UseImmed,
   input  logic [REG_W-1:0] currRs,
   input  logic [REG_W-1:0] currRt,
   input  logic [REG_W-1:0] prevRt,
   input  logic [REG_W-1:0] EX_Rw,
   input  logic [REG_W-1:0] MEM_Rw,
   input  logic             EX_RegWrite,
   input  logic             MEM_RegWrite,
   output logic             IF_write,
   output logic             PC_write,
   output logic             bubble,
   output logic [1:0]       addrSel,
   output logic             Mispredict,
   output logic             UpdValid,
   output logic             UpdTaken,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam flush_cnt_t FLUSH_INIT = flush_init(FLUSH_CYCLES);

   state_t     state, state_nxt;
   flush_cnt_t cnt, cnt_nxt;

   logic ld_hazard, jr_hazard, stall;
   logic pred;
   logic stall_inc, flush_inc;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   // $zero never carries a real dependency, so a load into r0 cannot stall.
   // currRt only matters when the ID instruction actually reads it.
   always_comb begin
      ld_hazard = memReadEX && (prevRt != '0) &&
                  ((currRs == prevRt) ||
                   ((currRt == prevRt) && !UseShamt && !UseImmed));
   end

   // jr reads its target in ID, so any older writer still in EX or MEM holds
   // it back; there is no forwarding path into the ID jump-register read.
   always_comb begin
      jr_hazard = Jr && ((EX_RegWrite  && (EX_Rw  == currRs)) ||
                         (MEM_RegWrite && (MEM_Rw == currRs)));
   end

   assign stall = ld_hazard || jr_hazard;
   assign pred  = (PRED_EXT != 0) ? PredTaken : 1'b0;

   // ---------------------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      IF_write   = 1'b1;
      PC_write   = 1'b1;
      bubble     = 1'b0;
      addrSel    = ADDR_SEQ;
      Mispredict = 1'b0;
      UpdValid   = 1'b0;
      UpdTaken   = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      unique case (state)
         RUN: begin
            if (stall) begin
               // Freeze IF and PC and hold ID; a bubble goes into EX. Any
               // branch in ID is resolved again once the hazard clears, so it
               // must not train the predictor yet.
               IF_write  = 1'b0;
               PC_write  = 1'b0;
               bubble    = 1'b1;
               stall_inc = 1'b1;
            end else if (Branch) begin
               // Branch has priority over Jump when both are decoded.
               UpdValid = 1'b1;
               UpdTaken = ALUZero;
               if (ALUZero != pred) begin
                  IF_write   = 1'b0;
                  bubble     = 1'b1;
                  addrSel    = ALUZero ? ADDR_BR_TGT : ADDR_BR_FALL;
                  Mispredict = 1'b1;
                  flush_inc  = 1'b1;
                  state_nxt  = FLUSH;
                  cnt_nxt    = FLUSH_INIT;
               end
            end else if (Jump) begin
               // The jump itself still issues down the pipe (no bubble).
               IF_write  = 1'b0;
               addrSel   = ADDR_JUMP;
               flush_inc = 1'b1;
               state_nxt = FLUSH;
               cnt_nxt   = FLUSH_INIT;
            end
         end

         FLUSH: begin
            // ID holds a wrong-path instruction: squash it and ignore its
            // decode. IF/ID reopens on the last flush cycle so the redirected
            // instruction lands in ID when RUN resumes.
            bubble   = 1'b1;
            IF_write = (cnt == '0);
            if (cnt == '0)
               state_nxt = RUN;
            else
               cnt_nxt = cnt - 1'b1;
         end

         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase

      // While reset is held the pipeline must see plain sequential fetch,
      // whatever the ID inputs say.
      if (Rst) begin
         state_nxt  = RUN;
         cnt_nxt    = '0;
         IF_write   = 1'b1;
         PC_write   = 1'b1;
         bubble     = 1'b0;
         addrSel    = ADDR_SEQ;
         Mispredict = 1'b0;
         UpdValid   = 1'b0;
         UpdTaken   = 1'b0;
         stall_inc  = 1'b0;
         flush_inc  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .inc   (stall_inc),
      .count (StallCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .inc   (flush_inc),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl_bp.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_bp
//   Bench for hazard_ctrl_bp. dut: PRED_EXT=1, FLUSH_CYCLES=2, CNT_W=3 (small
//   counters so saturation is reachable). dut0: PRED_EXT=0, FLUSH_CYCLES=1,
//   CNT_W=4, fed from the same inputs. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_bp;

   localparam int CW  = 3;
   localparam int CW0 = 4;

   // Output vector {IF_write, PC_write, bubble, addrSel, Mispredict, UpdValid, UpdTaken}
   localparam logic [7:0] O_NORM  = 8'b1100_0000;
   localparam logic [7:0] O_STALL = 8'b0010_0000;
   localparam logic [7:0] O_JUMP  = 8'b0100_1000;
   localparam logic [7:0] O_FL    = 8'b0110_0000;
   localparam logic [7:0] O_FL0   = 8'b1110_0000;
   localparam logic [7:0] O_MP_T  = 8'b0111_0111;
   localparam logic [7:0] O_MP_N  = 8'b0111_1110;
   localparam logic [7:0] O_OK_T  = 8'b1100_0011;
   localparam logic [7:0] O_OK_N  = 8'b1100_0010;

   typedef struct packed {
      logic       jump, jr, branch, alu_zero, pred_taken, mem_read, use_shamt, use_immed;
      logic [4:0] rs, rt, prev_rt, ex_rw, mem_rw;
      logic       ex_wr, mem_wr;
   } stim_t;

   typedef struct packed {
      logic [7:0]    o;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   logic Jump, Jr, Branch, ALUZero, PredTaken, memReadEX, UseShamt, UseImmed;
   logic [4:0] currRs, currRt, prevRt, EX_Rw, MEM_Rw;
   logic EX_RegWrite, MEM_RegWrite;

   logic IF_write, PC_write, bubble, Mispredict, UpdValid, UpdTaken;
   logic [1:0] addrSel;
   logic [CW-1:0] StallCount, FlushCount;

   logic IF_write0, PC_write0, bubble0, Mispredict0, UpdValid0, UpdTaken0;
   logic [1:0] addrSel0;
   logic [CW0-1:0] StallCount0, FlushCount0;

   exp_t        exp_q[$];
   logic [11:0] exp0_q[$];
   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   hazard_ctrl_bp #(.REG_W(5), .FLUSH_CYCLES(2), .PRED_EXT(1), .CNT_W(CW)) dut (
      .Clk(Clk), .Rst(Rst), .Jump(Jump), .Jr(Jr), .Branch(Branch), .ALUZero(ALUZero),
      .PredTaken(PredTaken), .memReadEX(memReadEX), .UseShamt(UseShamt), .UseImmed(UseImmed),
      .currRs(currRs), .currRt(currRt), .prevRt(prevRt), .EX_Rw(EX_Rw), .MEM_Rw(MEM_Rw),
      .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite),
      .IF_write(IF_write), .PC_write(PC_write), .bubble(bubble), .addrSel(addrSel),
      .Mispredict(Mispredict), .UpdValid(UpdValid), .UpdTaken(UpdTaken),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   hazard_ctrl_bp #(.REG_W(5), .FLUSH_CYCLES(1), .PRED_EXT(0), .CNT_W(CW0)) dut0 (
      .Clk(Clk), .Rst(Rst), .Jump(Jump), .Jr(Jr), .Branch(Branch), .ALUZero(ALUZero),
      .PredTaken(PredTaken), .memReadEX(memReadEX), .UseShamt(UseShamt), .UseImmed(UseImmed),
      .currRs(currRs), .currRt(currRt), .prevRt(prevRt), .EX_Rw(EX_Rw), .MEM_Rw(MEM_Rw),
      .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite),
      .IF_write(IF_write0), .PC_write(PC_write0), .bubble(bubble0), .addrSel(addrSel0),
      .Mispredict(Mispredict0), .UpdValid(UpdValid0), .UpdTaken(UpdTaken0),
      .StallCount(StallCount0), .FlushCount(FlushCount0)
   );

   function automatic logic [7:0] obs();
      return {IF_write, PC_write, bubble, addrSel, Mispredict, UpdValid, UpdTaken};
   endfunction

   function automatic logic [7:0] obs0();
      return {IF_write0, PC_write0, bubble0, addrSel0, Mispredict0, UpdValid0, UpdTaken0};
   endfunction

   function automatic exp_t mk(input logic [7:0] o, input int sc, input int fc);
      exp_t e;
      e.o  = o;
      e.sc = CW'(sc);
      e.fc = CW'(fc);
      return e;
   endfunction

   // Stimulus builders
   function automatic stim_t s_ld();           // load-use on rt (r8)
      stim_t s = '0;
      s.mem_read = 1'b1; s.prev_rt = 5'd8; s.rt = 5'd8; s.rs = 5'd1;
      return s;
   endfunction

   function automatic stim_t s_br(input logic pt, input logic az);
      stim_t s = '0;
      s.branch = 1'b1; s.pred_taken = pt; s.alu_zero = az;
      return s;
   endfunction

   function automatic stim_t s_jmp();
      stim_t s = '0;
      s.jump = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      Jump = s.jump; Jr = s.jr; Branch = s.branch; ALUZero = s.alu_zero;
      PredTaken = s.pred_taken; memReadEX = s.mem_read; UseShamt = s.use_shamt;
      UseImmed = s.use_immed; currRs = s.rs; currRt = s.rt; prevRt = s.prev_rt;
      EX_Rw = s.ex_rw; MEM_Rw = s.mem_rw; EX_RegWrite = s.ex_wr; MEM_RegWrite = s.mem_wr;
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      apply('0);
      Rst = 1'b1;
      #2;
      Rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      exp_t e, got;
      // Reset held with a mispredicting branch and a load hazard on the inputs.
      Rst = 1'b1;
      apply(s_br(1'b0, 1'b1) | s_ld());
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(O_NORM, 0, 0));
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
      Rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_load_use();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e, got;
      do_reset();
      st.push_back(s_ld());                         ex.push_back(mk(O_STALL, 0, 0));
      st.push_back(s_ld());                         ex.push_back(mk(O_STALL, 1, 0));
      st.push_back('0);                             ex.push_back(mk(O_NORM,  2, 0));
      s = s_ld(); s.use_immed = 1'b1;  st.push_back(s); ex.push_back(mk(O_NORM,  2, 0));
      s = s_ld(); s.prev_rt = 5'd0; s.rt = 5'd0;
                                      st.push_back(s); ex.push_back(mk(O_NORM,  2, 0));
      s = s_ld(); s.use_immed = 1'b1; s.rs = 5'd8;
                                      st.push_back(s); ex.push_back(mk(O_STALL, 2, 0));
      s = s_ld(); s.use_shamt = 1'b1;  st.push_back(s); ex.push_back(mk(O_NORM,  3, 0));
      st.push_back('0);                             ex.push_back(mk(O_NORM,  3, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL load_use[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_jr();
      stim_t st[$];
      exp_t  ex[$];
      stim_t s;
      exp_t  e, got;
      do_reset();
      s = '0; s.jump = 1'b1; s.jr = 1'b1; s.rs = 5'd31; s.mem_rw = 5'd31; s.mem_wr = 1'b1;
      st.push_back(s);                 ex.push_back(mk(O_STALL, 0, 0));
      s.mem_wr = 1'b0; st.push_back(s); ex.push_back(mk(O_JUMP,  1, 0));
      st.push_back(s);                 ex.push_back(mk(O_FL,    1, 1));
      st.push_back(s);                 ex.push_back(mk(O_FL0,   1, 1));
      s = '0; s.jr = 1'b1; s.rs = 5'd31; s.ex_rw = 5'd31; s.ex_wr = 1'b1;
      st.push_back(s);                 ex.push_back(mk(O_STALL, 1, 1));
      s.ex_rw = 5'd4;  st.push_back(s); ex.push_back(mk(O_NORM,  2, 1));
      st.push_back('0);                ex.push_back(mk(O_NORM,  2, 1));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL jr[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_branch_ext();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e, got;
      do_reset();
      st.push_back(s_br(1'b1, 1'b0));            ex.push_back(mk(O_MP_N,  0, 0));
      // Wrong-path decode during FLUSH must be ignored.
      st.push_back(s_ld() | s_jmp() | s_br(1'b0, 1'b1));
                                                 ex.push_back(mk(O_FL,    0, 1));
      st.push_back(s_ld() | s_jmp());            ex.push_back(mk(O_FL0,   0, 1));
      st.push_back(s_br(1'b1, 1'b1));            ex.push_back(mk(O_OK_T,  0, 1));
      st.push_back(s_br(1'b0, 1'b1));            ex.push_back(mk(O_MP_T,  0, 1));
      st.push_back('0);                          ex.push_back(mk(O_FL,    0, 2));
      st.push_back('0);                          ex.push_back(mk(O_FL0,   0, 2));
      st.push_back(s_br(1'b0, 1'b0));            ex.push_back(mk(O_OK_N,  0, 2));
      st.push_back(s_br(1'b1, 1'b1) | s_jmp());  ex.push_back(mk(O_OK_T,  0, 2));
      st.push_back(s_br(1'b0, 1'b1) | s_ld());   ex.push_back(mk(O_STALL, 0, 2));
      st.push_back('0);                          ex.push_back(mk(O_NORM,  1, 2));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL branch_ext[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Static not-taken instance: PredTaken must be ignored, one flush cycle.
   task automatic test_static();
      stim_t       st[$];
      logic [11:0] ex[$];
      logic [11:0] e, got;
      do_reset();
      st.push_back(s_br(1'b1, 1'b1));  ex.push_back({O_MP_T, 4'd0});
      st.push_back(s_jmp() | s_ld());  ex.push_back({O_FL0,  4'd1});
      st.push_back(s_br(1'b1, 1'b0));  ex.push_back({O_OK_N, 4'd1});
      st.push_back(s_jmp());           ex.push_back({O_JUMP, 4'd1});
      st.push_back('0);                ex.push_back({O_FL0,  4'd2});
      st.push_back('0);                ex.push_back({O_NORM, 4'd2});
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         exp0_q.push_back(ex[i]);
         @(negedge Clk);
         e = exp0_q.pop_front();
         got = {obs0(), FlushCount0};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL static[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_back_to_back();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e, got;
      do_reset();
      st.push_back(s_jmp() | s_ld());  ex.push_back(mk(O_STALL, 0, 0));
      st.push_back(s_jmp() | s_ld());  ex.push_back(mk(O_STALL, 1, 0));
      st.push_back(s_jmp());           ex.push_back(mk(O_JUMP,  2, 0));
      st.push_back('0);                ex.push_back(mk(O_FL,    2, 1));
      st.push_back('0);                ex.push_back(mk(O_FL0,   2, 1));
      st.push_back(s_jmp());           ex.push_back(mk(O_JUMP,  2, 1));
      st.push_back('0);                ex.push_back(mk(O_FL,    2, 2));
      st.push_back('0);                ex.push_back(mk(O_FL0,   2, 2));
      st.push_back('0);                ex.push_back(mk(O_NORM,  2, 2));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_sat();
      exp_t e, got;
      do_reset();
      // Enter FLUSH, then hit reset in the middle of it.
      apply(s_jmp());
      exp_q.push_back(mk(O_JUMP, 0, 0));
      @(negedge Clk);
      e = exp_q.pop_front();
      got = {obs(), StallCount, FlushCount};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL rst_mid[jump] got=%h exp=%h", got, e);
      end
      next_cycle();
      apply('0);
      exp_q.push_back(mk(O_FL, 0, 1));
      @(negedge Clk);
      e = exp_q.pop_front();
      got = {obs(), StallCount, FlushCount};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL rst_mid[flush] got=%h exp=%h", got, e);
      end
      #1;
      apply(s_br(1'b0, 1'b1));
      Rst = 1'b1;
      exp_q.push_back(mk(O_NORM, 0, 0));
      #1;
      e = exp_q.pop_front();
      got = {obs(), StallCount, FlushCount};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL rst_mid[async] got=%h exp=%h", got, e);
      end
      Rst = 1'b0;
      apply('0);
      next_cycle();
      // Back in RUN, not in the last flush cycle.
      exp_q.push_back(mk(O_NORM, 0, 0));
      @(negedge Clk);
      e = exp_q.pop_front();
      got = {obs(), StallCount, FlushCount};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL rst_mid[after] got=%h exp=%h", got, e);
      end
      next_cycle();
      // Saturation: 9 stall cycles on a 3-bit counter, then one idle cycle.
      for (int i = 0; i < 10; i++) begin
         apply(i < 9 ? s_ld() : stim_t'('0));
         exp_q.push_back(mk(i < 9 ? O_STALL : O_NORM, (i < 7) ? i : 7, 0));
         @(negedge Clk);
         e = exp_q.pop_front();
         got = {obs(), StallCount, FlushCount};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL sat[%0d] got=%h exp=%h", i, got, e);
         end
         next_cycle();
      end
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      Rst = 1'b1;
      apply('0);
      test_reset();
      test_load_use();
      test_jr();
      test_branch_ext();
      test_static();
      test_back_to_back();
      test_reset_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
